// File: rtl/cache_arbiter.sv
// cache_arbiter: shares one physical-memory port between the L1 instruction
// and data caches. One grant at a time, held until pmem_resp, with ties
// broken by alternating between the two caches.
module cache_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  // Instruction cache side
  input  logic                  i_pmem_read,
  input  logic [ADDR_WIDTH-1:0] i_pmem_address,
  output logic [LINE_WIDTH-1:0] i_pmem_rdata,
  output logic                  i_pmem_resp,
  // Data cache side
  input  logic                  d_pmem_read,
  input  logic                  d_pmem_write,
  input  logic [ADDR_WIDTH-1:0] d_pmem_address,
  input  logic [LINE_WIDTH-1:0] d_pmem_wdata,
  output logic [LINE_WIDTH-1:0] d_pmem_rdata,
  output logic                  d_pmem_resp,
  // Memory side
  output logic                  pmem_read,
  output logic                  pmem_write,
  output logic [ADDR_WIDTH-1:0] pmem_address,
  output logic [LINE_WIDTH-1:0] pmem_wdata,
  input  logic [LINE_WIDTH-1:0] pmem_rdata,
  input  logic                  pmem_resp,
  // Grant strobes for performance monitors
  output logic                  grant_instr,
  output logic                  grant_data
);

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StInstr = 2'd1,
    StData  = 2'd2
  } state_e;

  state_e r_state;
  state_e w_state_next;
  // 0: last grant went to the instruction cache, 1: to the data cache
  logic   r_last_grant;
  logic   w_last_grant_next;
  logic   w_i_req;
  logic   w_d_req;

  assign w_i_req = i_pmem_read;
  assign w_d_req = d_pmem_read | d_pmem_write;

  // State and tie-break history registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= StIdle;
      r_last_grant <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_last_grant <= w_last_grant_next;
    end
  end

  // Next-state: grant from IDLE only; a grant is released only by pmem_resp,
  // which always leaves one IDLE cycle so a stale request is never re-granted
  always_comb begin
    w_state_next      = r_state;
    w_last_grant_next = r_last_grant;
    unique case (r_state)
      StIdle: begin
        if (w_i_req && w_d_req) begin
          if (r_last_grant) begin
            w_state_next      = StInstr;
            w_last_grant_next = 1'b0;
          end else begin
            w_state_next      = StData;
            w_last_grant_next = 1'b1;
          end
        end else if (w_d_req) begin
          w_state_next      = StData;
          w_last_grant_next = 1'b1;
        end else if (w_i_req) begin
          w_state_next      = StInstr;
          w_last_grant_next = 1'b0;
        end
      end
      StInstr, StData: begin
        if (pmem_resp) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Memory-port mux, response routing and grant strobes
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = '0;
    pmem_wdata   = '0;
    i_pmem_resp  = 1'b0;
    d_pmem_resp  = 1'b0;
    grant_instr  = 1'b0;
    grant_data   = 1'b0;
    unique case (r_state)
      StInstr: begin
        pmem_read    = i_pmem_read;
        pmem_address = i_pmem_address;
        i_pmem_resp  = pmem_resp;
        grant_instr  = 1'b1;
      end
      StData: begin
        // Writeback wins if the data cache raises both commands
        pmem_write   = d_pmem_write;
        pmem_read    = d_pmem_read & ~d_pmem_write;
        pmem_address = d_pmem_address;
        pmem_wdata   = d_pmem_wdata;
        d_pmem_resp  = pmem_resp;
        grant_data   = 1'b1;
      end
      default: ;
    endcase
  end

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

endmodule
